// File: rtl/i2c_slave_pkg.sv
`default_nettype none
// i2c_slave_pkg: shared state encoding and constants for the I2C responder.
package i2c_slave_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_LOAD,
    RD_DATA,
    RD_ACK
  } i2c_slv_state_e;

  localparam int         BIT_CNT_W    = 3;
  localparam logic       ACK          = 1'b0;
  localparam logic       NACK         = 1'b1;
  localparam logic [6:0] DEFAULT_ADDR = 7'h50;

endpackage
`default_nettype wire

// File: rtl/i2c_slave_port_if.sv
`default_nettype none
// i2c_slave_port_if: pad pairs plus local byte write/read streams of the I2C responder.
interface i2c_slave_port_if;

  logic       scl_i;
  logic       sda_i;
  logic       scl_o;
  logic       scl_t;
  logic       sda_o;
  logic       sda_t;
  logic       wr_vld;
  logic [7:0] wr_data;
  logic       wr_first;
  logic       rd_req;
  logic       rd_vld;
  logic [7:0] rd_data;
  logic       rd_miss;
  logic       start_det;
  logic       stop_det;
  logic       busy;

  modport slave (
    input  scl_i, sda_i, rd_vld, rd_data,
    output scl_o, scl_t, sda_o, sda_t, wr_vld, wr_data, wr_first,
           rd_req, rd_miss, start_det, stop_det, busy
  );

  modport master (
    output scl_i, sda_i, rd_vld, rd_data,
    input  scl_o, scl_t, sda_o, sda_t, wr_vld, wr_data, wr_first,
           rd_req, rd_miss, start_det, stop_det, busy
  );

endinterface
`default_nettype wire

// File: rtl/i2c_line_filter.sv
`default_nettype none
// i2c_line_filter: 2-flop synchronizer, FILTER-sample debounce and registered edge pulses.
module i2c_line_filter #(
  parameter int FILTER = 3
) (
  input  wire  clock,
  input  wire  rst,
  input  wire  pad,
  output logic level,
  output logic rise,
  output logic fall
);

  logic       sync1;
  logic       sync2;
  logic [3:0] cnt;

  // Idle bus level is high, so reset to 1 to avoid a false edge after reset.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= 4'd0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync1 <= pad;
      sync2 <= sync1;
      rise  <= 1'b0;
      fall  <= 1'b0;
      if (sync2 == level) begin
        cnt <= 4'd0;
      end else if (cnt == 4'(FILTER - 1)) begin
        level <= sync2;
        cnt   <= 4'd0;
        rise  <= sync2;
        fall  <= ~sync2;
      end else begin
        cnt <= cnt + 4'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/i2c_slave_port.sv
`default_nettype none
// i2c_slave_port: I2C responder with 7-bit address match, byte write stream and byte read source.
// Build option: I2C_SLAVE_STRETCH_EN holds SCL low while waiting for a late read byte.
module i2c_slave_port
  import i2c_slave_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = DEFAULT_ADDR,
  parameter int         FILTER     = 3,
  parameter int         TSU        = 4
) (
  input wire              clock,
  input wire              rst,
  i2c_slave_port_if.slave bus
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_slv_state_e       state;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [6:0]           shreg;
  logic [7:0]           tx_sh;
  logic                 rw, first, ack_on, tx_have, rd_wait;
  logic                 sda_t_r, wr_vld_r, wr_first_r, rd_req_r, start_r, stop_r, busy_r;
  logic [7:0]           wr_data_r;

  logic       take;
  logic [7:0] next_byte;
  logic       start_cond, stop_cond;

`ifdef I2C_SLAVE_STRETCH_EN
  logic       scl_t_r;
  logic       stretch;
  logic [7:0] tsu_cnt;
`else
  logic       rd_miss_r;
`endif

  i2c_line_filter #(.FILTER(FILTER)) u_scl_filter (
    .clock (clock), .rst (rst), .pad (bus.scl_i),
    .level (scl_lvl), .rise (scl_rise), .fall (scl_fall)
  );

  i2c_line_filter #(.FILTER(FILTER)) u_sda_filter (
    .clock (clock), .rst (rst), .pad (bus.sda_i),
    .level (sda_lvl), .rise (sda_rise), .fall (sda_fall)
  );

  assign start_cond = sda_fall & scl_lvl;
  assign stop_cond  = sda_rise & scl_lvl;
  assign take       = bus.rd_vld & rd_wait & ~tx_have;
  assign next_byte  = tx_have ? tx_sh : bus.rd_data;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= 7'd0;
      tx_sh      <= 8'd0;
      rw         <= 1'b0;
      first      <= 1'b0;
      ack_on     <= 1'b0;
      tx_have    <= 1'b0;
      rd_wait    <= 1'b0;
      sda_t_r    <= 1'b0;
      wr_vld_r   <= 1'b0;
      wr_data_r  <= 8'd0;
      wr_first_r <= 1'b0;
      rd_req_r   <= 1'b0;
      start_r    <= 1'b0;
      stop_r     <= 1'b0;
      busy_r     <= 1'b0;
`ifdef I2C_SLAVE_STRETCH_EN
      scl_t_r    <= 1'b0;
      stretch    <= 1'b0;
      tsu_cnt    <= 8'd0;
`else
      rd_miss_r  <= 1'b0;
`endif
    end else begin
      wr_vld_r   <= 1'b0;
      wr_first_r <= 1'b0;
      rd_req_r   <= 1'b0;
      start_r    <= 1'b0;
      stop_r     <= 1'b0;
`ifndef I2C_SLAVE_STRETCH_EN
      rd_miss_r  <= 1'b0;
`endif
      if (stop_cond || start_cond) begin
        // Bus conditions win over any data edge seen in the same cycle.
        state   <= stop_cond ? IDLE : ADDR;
        start_r <= ~stop_cond;
        stop_r  <= stop_cond;
        bit_cnt <= '0;
        sda_t_r <= 1'b0;
        busy_r  <= 1'b0;
        ack_on  <= 1'b0;
        tx_have <= 1'b0;
        rd_wait <= 1'b0;
`ifdef I2C_SLAVE_STRETCH_EN
        scl_t_r <= 1'b0;
        stretch <= 1'b0;
`endif
      end else begin
        case (state)
          IDLE: ;
          ADDR, WR_DATA: begin
            if (scl_rise) begin
              shreg   <= {shreg[5:0], sda_lvl};
              bit_cnt <= bit_cnt + 1'b1;
              if (&bit_cnt) begin
                ack_on <= 1'b0;
                if (state == WR_DATA) begin
                  wr_vld_r   <= 1'b1;
                  wr_data_r  <= {shreg, sda_lvl};
                  wr_first_r <= first;
                  first      <= 1'b0;
                  state      <= WR_ACK;
                end else if (shreg == SLAVE_ADDR) begin
                  rw     <= sda_lvl;
                  first  <= 1'b1;
                  busy_r <= 1'b1;
                  state  <= ADDR_ACK;
                end else begin
                  state <= IDLE;
                end
              end
            end
          end
          ADDR_ACK, WR_ACK: begin
            if (scl_fall) begin
              ack_on  <= ~ack_on;
              sda_t_r <= ~ack_on;
              if (ack_on) begin
                bit_cnt <= '0;
                state   <= WR_DATA;
              end
            end else if (scl_rise && ack_on && rw && state == ADDR_ACK) begin
              // Read: request the first byte during the ACK high phase; the ACK
              // drive is replaced by the MSB at the following SCL fall.
              rd_req_r <= 1'b1;
              rd_wait  <= 1'b1;
              ack_on   <= 1'b0;
              state    <= RD_LOAD;
            end
          end
          RD_LOAD: begin
            if (take) begin
              tx_sh   <= bus.rd_data;
              tx_have <= 1'b1;
              rd_wait <= 1'b0;
            end
`ifdef I2C_SLAVE_STRETCH_EN
            if (stretch) begin
              if (take) begin
                sda_t_r <= ~bus.rd_data[7];
                tsu_cnt <= 8'(TSU);
              end else if (tx_have) begin
                if (tsu_cnt <= 8'd1) begin
                  scl_t_r <= 1'b0;
                  stretch <= 1'b0;
                  tx_have <= 1'b0;
                  bit_cnt <= '0;
                  state   <= RD_DATA;
                end else begin
                  tsu_cnt <= tsu_cnt - 8'd1;
                end
              end
            end else if (scl_fall) begin
              if (tx_have || take) begin
                sda_t_r <= ~next_byte[7];
                tx_sh   <= next_byte;
                tx_have <= 1'b0;
                bit_cnt <= '0;
                state   <= RD_DATA;
              end else begin
                scl_t_r <= 1'b1;
                stretch <= 1'b1;
                sda_t_r <= 1'b0;
              end
            end
`else
            if (scl_fall) begin
              bit_cnt <= '0;
              tx_have <= 1'b0;
              state   <= RD_DATA;
              if (tx_have || take) begin
                sda_t_r <= ~next_byte[7];
                tx_sh   <= next_byte;
              end else begin
                sda_t_r   <= 1'b0;
                tx_sh     <= 8'hFF;
                rd_miss_r <= 1'b1;
                rd_wait   <= 1'b0;
              end
            end
`endif
          end
          RD_DATA: begin
            if (scl_fall) begin
              bit_cnt <= bit_cnt + 1'b1;
              if (&bit_cnt) begin
                sda_t_r <= 1'b0;
                state   <= RD_ACK;
              end else begin
                sda_t_r <= ~tx_sh[6];
                tx_sh   <= {tx_sh[6:0], 1'b1};
              end
            end
          end
          RD_ACK: begin
            if (scl_rise) begin
              if (sda_lvl == ACK) begin
                rd_req_r <= 1'b1;
                rd_wait  <= 1'b1;
                state    <= RD_LOAD;
              end else begin
                state <= IDLE;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.scl_o     = 1'b0;
  assign bus.sda_o     = 1'b0;
  assign bus.sda_t     = sda_t_r;
  assign bus.wr_vld    = wr_vld_r;
  assign bus.wr_data   = wr_data_r;
  assign bus.wr_first  = wr_first_r;
  assign bus.rd_req    = rd_req_r;
  assign bus.start_det = start_r;
  assign bus.stop_det  = stop_r;
  assign bus.busy      = busy_r;
`ifdef I2C_SLAVE_STRETCH_EN
  assign bus.scl_t     = scl_t_r;
  assign bus.rd_miss   = 1'b0;
`else
  assign bus.scl_t     = 1'b0;
  assign bus.rd_miss   = rd_miss_r;
`endif

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_port.sv
`default_nettype none
// tb_i2c_slave_port: directed I2C master bench for i2c_slave_port with a local byte responder.
module tb_i2c_slave_port;

  localparam int Q     = 10;
  localparam int H     = 20;
  localparam int TSU_V = 4;

  logic clock;
  logic rst;
  logic m_scl;
  logic m_sda;

  i2c_slave_port_if bus_if ();

  i2c_slave_port #(
    .SLAVE_ADDR (7'h50),
    .FILTER     (3),
    .TSU        (TSU_V)
  ) dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus_if)
  );

  // Open-drain wired-AND of bench master and DUT drives.
  assign bus_if.scl_i = m_scl & ~(bus_if.scl_t & ~bus_if.scl_o);
  assign bus_if.sda_i = m_sda & ~(bus_if.sda_t & ~bus_if.sda_o);

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total;
  int bad;
  int wr_cnt;
  int rd_req_cnt;
  int rd_miss_cnt;
  int start_cnt;
  int stop_cnt;
  int sda_drv_cnt;
  int hold_cnt;
  int stretch_seen;
  logic [7:0] wr_log [0:63];
  logic       wr_first_log [0:63];

  logic [7:0] rd_bytes [0:7];
  int         rd_idx;
  int         rd_delay;
  logic       resp_en;

  initial begin
    total = 0; bad = 0; wr_cnt = 0; rd_req_cnt = 0; rd_miss_cnt = 0;
    start_cnt = 0; stop_cnt = 0; sda_drv_cnt = 0; hold_cnt = 0; stretch_seen = 0;
  end

  always @(negedge clock) begin
    if (bus_if.wr_vld === 1'b1) begin
      wr_log[wr_cnt[5:0]]       = bus_if.wr_data;
      wr_first_log[wr_cnt[5:0]] = bus_if.wr_first;
      wr_cnt++;
    end
    if (bus_if.rd_req === 1'b1)    rd_req_cnt++;
    if (bus_if.rd_miss === 1'b1)   rd_miss_cnt++;
    if (bus_if.start_det === 1'b1) start_cnt++;
    if (bus_if.stop_det === 1'b1)  stop_cnt++;
    if (bus_if.sda_t === 1'b1)     sda_drv_cnt++;
    if (bus_if.scl_t === 1'b1 && bus_if.sda_t === 1'b1) hold_cnt++;
  end

  // Local byte source answering rd_req after rd_delay cycles.
  initial begin
    bus_if.rd_vld  = 1'b0;
    bus_if.rd_data = 8'h00;
    forever begin
      @(negedge clock);
      if (resp_en && bus_if.rd_req === 1'b1) begin
        repeat (rd_delay) @(negedge clock);
        bus_if.rd_data = rd_bytes[rd_idx[2:0]];
        rd_idx++;
        bus_if.rd_vld  = 1'b1;
        @(negedge clock);
        bus_if.rd_vld  = 1'b0;
      end
    end
  end

  task automatic clk_bit(input logic b, output logic r);
    int waited;
    m_sda = b;
    repeat (Q) @(negedge clock);
    m_scl  = 1'b1;
    waited = 0;
    while (bus_if.scl_i !== 1'b1 && waited < 5000) begin
      @(negedge clock);
      waited++;
    end
    stretch_seen += waited;
    if (waited >= 5000) begin
      total++; bad++;
      $display("FAIL scl_stretch_timeout waited=%0d limit=%0d", waited, 5000);
    end
    repeat (Q) @(negedge clock);
    r = bus_if.sda_i;
    repeat (Q) @(negedge clock);
    m_scl = 1'b0;
    repeat (Q) @(negedge clock);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], r);
    clk_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic ack_bit, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, r);
      d[i] = r;
    end
    clk_bit(ack_bit, r);
  endtask

  task automatic bus_start();
    m_sda = 1'b0;
    repeat (H) @(negedge clock);
    m_scl = 1'b0;
    repeat (Q) @(negedge clock);
  endtask

  task automatic bus_rstart();
    m_sda = 1'b1;
    repeat (Q) @(negedge clock);
    m_scl = 1'b1;
    repeat (H) @(negedge clock);
    m_sda = 1'b0;
    repeat (H) @(negedge clock);
    m_scl = 1'b0;
    repeat (Q) @(negedge clock);
  endtask

  task automatic bus_stop();
    m_sda = 1'b0;
    repeat (Q) @(negedge clock);
    m_scl = 1'b1;
    repeat (H) @(negedge clock);
    m_sda = 1'b1;
    repeat (H) @(negedge clock);
  endtask

  task automatic test_reset();
    logic [18:0] outs;
    rst = 1'b1;
    repeat (3) @(negedge clock);
    outs = {bus_if.scl_t, bus_if.sda_t, bus_if.scl_o, bus_if.sda_o, bus_if.wr_vld,
            bus_if.wr_first, bus_if.rd_req, bus_if.rd_miss, bus_if.start_det,
            bus_if.stop_det, bus_if.busy, bus_if.wr_data};
    total++;
    if (outs !== 19'd0) begin bad++; $display("FAIL reset_outputs got=%h exp=%h", outs, 19'd0); end
    rst = 1'b0;
    repeat (20) @(negedge clock);
    outs = {bus_if.scl_t, bus_if.sda_t, bus_if.scl_o, bus_if.sda_o, bus_if.wr_vld,
            bus_if.wr_first, bus_if.rd_req, bus_if.rd_miss, bus_if.start_det,
            bus_if.stop_det, bus_if.busy, bus_if.wr_data};
    total++;
    if (outs !== 19'd0) begin bad++; $display("FAIL idle_after_reset got=%h exp=%h", outs, 19'd0); end
  endtask

  task automatic test_write();
    int   w0, s0, p0;
    logic ack;
    w0 = wr_cnt; s0 = start_cnt; p0 = stop_cnt;
    bus_start();
    write_byte(8'hA0, ack);
    total++;
    if (ack !== 1'b0) begin bad++; $display("FAIL wr_addr_ack got=%b exp=%b", ack, 1'b0); end
    total++;
    if (bus_if.busy !== 1'b1) begin bad++; $display("FAIL wr_busy got=%b exp=%b", bus_if.busy, 1'b1); end
    write_byte(8'h12, ack);
    total++;
    if (ack !== 1'b0) begin bad++; $display("FAIL wr_data0_ack got=%b exp=%b", ack, 1'b0); end
    write_byte(8'h34, ack);
    total++;
    if (ack !== 1'b0) begin bad++; $display("FAIL wr_data1_ack got=%b exp=%b", ack, 1'b0); end
    bus_stop();
    repeat (10) @(negedge clock);
    total++;
    if (wr_cnt - w0 !== 2) begin bad++; $display("FAIL wr_count got=%0d exp=%0d", wr_cnt - w0, 2); end
    total++;
    if ({wr_log[w0[5:0]], wr_first_log[w0[5:0]]} !== {8'h12, 1'b1}) begin
      bad++; $display("FAIL wr_byte0 got=%h/%b exp=%h/%b", wr_log[w0[5:0]], wr_first_log[w0[5:0]], 8'h12, 1'b1);
    end
    total++;
    if ({wr_log[w0[5:0]+6'd1], wr_first_log[w0[5:0]+6'd1]} !== {8'h34, 1'b0}) begin
      bad++; $display("FAIL wr_byte1 got=%h/%b exp=%h/%b", wr_log[w0[5:0]+6'd1], wr_first_log[w0[5:0]+6'd1], 8'h34, 1'b0);
    end
    total++;
    if (start_cnt - s0 !== 1) begin bad++; $display("FAIL wr_start_det got=%0d exp=%0d", start_cnt - s0, 1); end
    total++;
    if (stop_cnt - p0 !== 1) begin bad++; $display("FAIL wr_stop_det got=%0d exp=%0d", stop_cnt - p0, 1); end
    total++;
    if (bus_if.busy !== 1'b0) begin bad++; $display("FAIL wr_busy_after_stop got=%b exp=%b", bus_if.busy, 1'b0); end
  endtask

  task automatic test_mismatch();
    int   w0, d0;
    logic ack;
    w0 = wr_cnt; d0 = sda_drv_cnt;
    bus_start();
    write_byte(8'h42, ack);
    total++;
    if (ack !== 1'b1) begin bad++; $display("FAIL mm_no_ack got=%b exp=%b", ack, 1'b1); end
    total++;
    if (bus_if.busy !== 1'b0) begin bad++; $display("FAIL mm_busy got=%b exp=%b", bus_if.busy, 1'b0); end
    bus_stop();
    repeat (10) @(negedge clock);
    total++;
    if (wr_cnt - w0 !== 0) begin bad++; $display("FAIL mm_wr_vld got=%0d exp=%0d", wr_cnt - w0, 0); end
    total++;
    if (sda_drv_cnt - d0 !== 0) begin bad++; $display("FAIL mm_sda_drive got=%0d exp=%0d", sda_drv_cnt - d0, 0); end
  endtask

  task automatic test_read();
    int         r0, m0;
    logic       ack;
    logic [7:0] d;
    r0 = rd_req_cnt; m0 = rd_miss_cnt;
    rd_bytes[0] = 8'h5A; rd_bytes[1] = 8'hC3; rd_idx = 0; rd_delay = 2;
    bus_start();
    write_byte(8'hA1, ack);
    total++;
    if (ack !== 1'b0) begin bad++; $display("FAIL rd_addr_ack got=%b exp=%b", ack, 1'b0); end
    read_byte(1'b0, d);
    total++;
    if (d !== 8'h5A) begin bad++; $display("FAIL rd_byte0 got=%h exp=%h", d, 8'h5A); end
    read_byte(1'b1, d);
    total++;
    if (d !== 8'hC3) begin bad++; $display("FAIL rd_byte1 got=%h exp=%h", d, 8'hC3); end
    total++;
    if (bus_if.sda_t !== 1'b0) begin bad++; $display("FAIL rd_release_after_nack got=%b exp=%b", bus_if.sda_t, 1'b0); end
    bus_stop();
    repeat (10) @(negedge clock);
    total++;
    if (rd_req_cnt - r0 !== 2) begin bad++; $display("FAIL rd_req_count got=%0d exp=%0d", rd_req_cnt - r0, 2); end
    total++;
    if (rd_miss_cnt - m0 !== 0) begin bad++; $display("FAIL rd_no_miss got=%0d exp=%0d", rd_miss_cnt - m0, 0); end
  endtask

  task automatic test_back_to_back();
    int         w0, s0, p0;
    logic       ack;
    logic [7:0] d;
    w0 = wr_cnt; s0 = start_cnt; p0 = stop_cnt;
    rd_bytes[0] = 8'h99; rd_idx = 0; rd_delay = 1;
    bus_start();
    write_byte(8'hA0, ack);
    write_byte(8'h07, ack);
    total++;
    if (ack !== 1'b0) begin bad++; $display("FAIL rs_wr_ack got=%b exp=%b", ack, 1'b0); end
    bus_rstart();
    write_byte(8'hA1, ack);
    total++;
    if (ack !== 1'b0) begin bad++; $display("FAIL rs_rd_addr_ack got=%b exp=%b", ack, 1'b0); end
    read_byte(1'b1, d);
    total++;
    if (d !== 8'h99) begin bad++; $display("FAIL rs_rd_byte got=%h exp=%h", d, 8'h99); end
    total++;
    if (stop_cnt - p0 !== 0) begin bad++; $display("FAIL rs_no_stop got=%0d exp=%0d", stop_cnt - p0, 0); end
    total++;
    if (start_cnt - s0 !== 2) begin bad++; $display("FAIL rs_start_det got=%0d exp=%0d", start_cnt - s0, 2); end
    bus_stop();
    repeat (10) @(negedge clock);
    total++;
    if ({wr_cnt - w0, wr_log[w0[5:0]], wr_first_log[w0[5:0]]} !== {32'd1, 8'h07, 1'b1}) begin
      bad++; $display("FAIL rs_wr_byte got=%0d/%h/%b exp=%0d/%h/%b", wr_cnt - w0, wr_log[w0[5:0]],
                      wr_first_log[w0[5:0]], 1, 8'h07, 1'b1);
    end
  endtask

  task automatic test_late_data();
    int         m0, h0, st0;
    logic       ack;
    logic [7:0] d;
    m0 = rd_miss_cnt; h0 = hold_cnt;
    rd_bytes[0] = 8'h3C; rd_idx = 0; rd_delay = 200;
    bus_start();
    write_byte(8'hA1, ack);
    st0 = stretch_seen;
    read_byte(1'b1, d);
    bus_stop();
    repeat (10) @(negedge clock);
`ifdef I2C_SLAVE_STRETCH_EN
    total++;
    if (d !== 8'h3C) begin bad++; $display("FAIL late_byte got=%h exp=%h", d, 8'h3C); end
    total++;
    if (stretch_seen - st0 < 100) begin bad++; $display("FAIL late_stretch got=%0d exp>=%0d", stretch_seen - st0, 100); end
    total++;
    if (hold_cnt - h0 !== TSU_V) begin bad++; $display("FAIL late_tsu got=%0d exp=%0d", hold_cnt - h0, TSU_V); end
    total++;
    if (rd_miss_cnt - m0 !== 0) begin bad++; $display("FAIL late_miss got=%0d exp=%0d", rd_miss_cnt - m0, 0); end
`else
    total++;
    if (d !== 8'hFF) begin bad++; $display("FAIL late_byte got=%h exp=%h", d, 8'hFF); end
    total++;
    if (rd_miss_cnt - m0 !== 1) begin bad++; $display("FAIL late_miss got=%0d exp=%0d", rd_miss_cnt - m0, 1); end
    total++;
    if (stretch_seen - st0 !== 0) begin bad++; $display("FAIL late_no_stretch got=%0d exp=%0d", stretch_seen - st0, 0); end
`endif
    repeat (20) @(negedge clock);
  endtask

  task automatic test_reset_mid_read();
    int   w0;
    logic ack;
    logic r;
    rd_bytes[0] = 8'h00; rd_idx = 0; rd_delay = 0;
    bus_start();
    write_byte(8'hA1, ack);
    for (int i = 0; i < 3; i++) clk_bit(1'b1, r);
    total++;
    if (bus_if.sda_t !== 1'b1) begin bad++; $display("FAIL mid_read_driving got=%b exp=%b", bus_if.sda_t, 1'b1); end
    rst = 1'b1;
    #1;
    total++;
    if ({bus_if.sda_t, bus_if.scl_t} !== 2'b00) begin
      bad++; $display("FAIL reset_release got=%b exp=%b", {bus_if.sda_t, bus_if.scl_t}, 2'b00);
    end
    m_scl = 1'b1;
    m_sda = 1'b1;
    repeat (10) @(negedge clock);
    rst = 1'b0;
    repeat (20) @(negedge clock);
    w0 = wr_cnt;
    bus_start();
    write_byte(8'hA0, ack);
    total++;
    if (ack !== 1'b0) begin bad++; $display("FAIL post_reset_ack got=%b exp=%b", ack, 1'b0); end
    write_byte(8'h55, ack);
    bus_stop();
    repeat (10) @(negedge clock);
    total++;
    if ({wr_cnt - w0, wr_log[w0[5:0]], wr_first_log[w0[5:0]]} !== {32'd1, 8'h55, 1'b1}) begin
      bad++; $display("FAIL post_reset_write got=%0d/%h/%b exp=%0d/%h/%b", wr_cnt - w0, wr_log[w0[5:0]],
                      wr_first_log[w0[5:0]], 1, 8'h55, 1'b1);
    end
  endtask

  initial begin
    rst      = 1'b1;
    m_scl    = 1'b1;
    m_sda    = 1'b1;
    resp_en  = 1'b1;
    rd_idx   = 0;
    rd_delay = 2;
    for (int i = 0; i < 8; i++) rd_bytes[i] = 8'h00;
    test_reset();
    test_write();
    test_mismatch();
    test_read();
    test_back_to_back();
    test_late_data();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/i2c_slave_port.md
# i2c_slave_port

I2C responder (slave) for the opposite end of the bus driven by `I2C_master`. Filters SCL/SDA and detects START/STOP. Decodes a 7-bit address, ACKs matching writes and streams the data bytes to a local byte interface. Serves reads from a local byte source. Uses the same split `*_o`/`*_t` pad convention as the master, so both can share one open-drain bus in the simple bench.

## Interface
Parameters:
- `SLAVE_ADDR`, 7'h50: 7-bit address this port answers to.
- `FILTER`, 3: number of consecutive equal synchronized samples required to accept a new SCL/SDA level (1..15).
- `TSU`, 4: clock cycles SDA is held stable before SCL is released after a stretch.

Ports:
- `clock` in 1: single clock; all logic on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `scl_i` in 1: SCL pad input.
- `sda_i` in 1: SDA pad input.
- `scl_o` out 1: SCL drive value (always 0 when driven).
- `scl_t` out 1: 1 = drive SCL with `scl_o`, 0 = release.
- `sda_o` out 1: SDA drive value.
- `sda_t` out 1: 1 = drive SDA with `sda_o`, 0 = release.
- `wr_vld` out 1: one-cycle pulse, `wr_data` valid.
- `wr_data` out 8: received byte.
- `wr_first` out 1: qualifies `wr_vld`; first data byte after the address.
- `rd_req` out 1: one-cycle pulse requesting the next transmit byte.
- `rd_vld` in 1: `rd_data` is valid; accepted in the first cycle it is high after `rd_req`.
- `rd_data` in 8: transmit byte.
- `rd_miss` out 1: one-cycle pulse, no byte arrived in time and 8'hFF was sent.
- `start_det` out 1: one-cycle pulse on START or repeated START.
- `stop_det` out 1: one-cycle pulse on STOP.
- `busy` out 1: high from an addressed ACK until STOP or a new START.

## Operation
- Input path:
  - 2-flop synchronizer, then an `FILTER`-sample debounce, then edge detect.
  - Produces `scl_rise`, `scl_fall`, `sda_rise` and `sda_fall`.
- START is SDA falling while filtered SCL is high. STOP is SDA rising while SCL is high.
- START moves any state to ADDR, with the bit counter cleared.
- STOP moves any state to IDLE and releases both lines.
- States (package enum): IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_LOAD, RD_DATA, RD_ACK.
- ADDR:
  - Shift SDA MSB-first on each `scl_rise`, 8 bits.
  - If bits[7:1] equal `SLAVE_ADDR`: go to ADDR_ACK and drive SDA low from the next `scl_fall`.
  - On mismatch: go to IDLE with no drive.
- ADDR_ACK:
  - On `scl_fall` ending the ACK bit, release SDA.
  - R/W=0: go to WR_DATA.
  - R/W=1: go to RD_LOAD.
  - `rd_req` is pulsed on the `scl_rise` of the ACK bit.
- WR_DATA:
  - After 8 bits: pulse `wr_vld` with `wr_data`, and `wr_first` for the first byte of the transfer.
  - Go to WR_ACK, driving SDA low for one bit; then return to WR_DATA.
  - Writes are always ACKed.
- RD_LOAD:
  - Latch `rd_data` on `rd_vld`.
  - On `scl_fall`, drive the MSB and go to RD_DATA.
- RD_DATA:
  - Drive the next bit on each `scl_fall`. SDA drive for 1 is release (`sda_t`=0); for 0, `sda_t`=1 and `sda_o`=0.
  - After 8 bits, release SDA and go to RD_ACK.
- RD_ACK: sample master ACK on `scl_rise`.
  - 0: pulse `rd_req`, go to RD_LOAD.
  - 1 (NACK): go to IDLE and wait for STOP or START.
- Bit counter is 3 bits and wraps 7→0 at each byte boundary.

## Timing
- Reset value of every output is 0, and the state is IDLE.
- Input latency: 2 + `FILTER` cycles from pad to filtered edge.
- SDA changes only 1 cycle after `scl_fall`; never while SCL is high except for its own release on STOP.
- `rd_req` to the data deadline is half an SCL period: `rd_vld` must arrive before the ACK-bit `scl_fall`.
- `rd_vld` before `rd_req`, or a second `rd_vld`: ignored.
- Simultaneous START/STOP with data edges: START/STOP takes priority.
- `rst` mid-byte releases both lines immediately (asynchronous).

## Configuration
- Macro: `I2C_SLAVE_STRETCH_EN`.
- Defined:
  - In RD_LOAD, if `scl_fall` arrives with no latched byte, drive SCL low.
  - When `rd_vld` arrives, drive the MSB, wait `TSU` cycles, then release SCL.
  - `rd_miss` is never asserted.
- Undefined:
  - `scl_t` is tied to 0.
  - A missing byte at `scl_fall` sends 8'hFF and pulses `rd_miss`.

## Structure
- Package `i2c_slave_pkg`: state enum `i2c_slv_state_e`, bit-count width, ACK/NACK constants, default address.
- Sub-module `i2c_line_filter`: synchronizer, debounce and edge detect. Instantiated once for SCL and once for SDA.

## Test plan
- Write: START, 0xA0, 0x12, 0x34, STOP → two ACKs plus the address ACK; `wr_vld` twice with 0x12 (`wr_first`=1) then 0x34; `stop_det` pulses once.
- Address mismatch: START, 0x42 → no ACK (SDA released on the 9th clock), no `wr_vld`, `busy` stays 0.
- Read: START, 0xA1, local `rd_vld` 0x5A then 0xC3; master ACK then NACK → bus shows 0x5A, 0xC3; `rd_req` pulses twice; state returns to IDLE.
- Repeated START: write 0xA0, 0x07, then START, 0xA1 → `start_det` twice, read begins with no STOP.
- Late data, stretch defined: `rd_vld` 200 cycles after `rd_req` → SCL is held low until data, then released `TSU` cycles later, and the byte is correct.
- Late data, stretch undefined: same stimulus → 0xFF on the bus and one `rd_miss` pulse.
- Reset mid-read: assert `rst` during bit 3 → `sda_t`=`scl_t`=0 at once; next START is decoded normally.
